// File: rtl/pong_pkg.sv
// Shared constants for the pong ball/collision blocks: direction codes,
// screen geometry, derived clamp limits, the motion FSM state type and a
// direction-code decoder.
package pong_pkg;

    // Direction codes produced by the collision controller
    localparam logic [3:0] DIR_SERVE = 4'd0;
    localparam logic [3:0] DIR_UL    = 4'd1;
    localparam logic [3:0] DIR_UR    = 4'd2;
    localparam logic [3:0] DIR_UR2   = 4'd3;
    localparam logic [3:0] DIR_DR    = 4'd4;
    localparam logic [3:0] DIR_DR2   = 4'd5;
    localparam logic [3:0] DIR_DL    = 4'd6;
    localparam logic [3:0] DIR_DL2   = 4'd7;
    localparam logic [3:0] DIR_UL2   = 4'd8;
    localparam logic [3:0] DIR_MISS  = 4'd9;
    localparam logic [3:0] DIR_HOLD  = 4'd10;

    localparam int SCR_W       = 640;
    localparam int SCR_H       = 480;
    localparam int BALL_R      = 10;
    localparam int WALL_MARGIN = 10;

    // Ball-centre limits: radius plus wall margin from every edge
    localparam int X_MIN = BALL_R + WALL_MARGIN;
    localparam int X_MAX = SCR_W - BALL_R - WALL_MARGIN;
    localparam int Y_MIN = BALL_R + WALL_MARGIN;
    localparam int Y_MAX = SCR_H - BALL_R - WALL_MARGIN;

    typedef enum logic {
        ST_SERVE = 1'b0,
        ST_MOVE  = 1'b1
    } motion_state_t;

    typedef struct packed {
        logic dx_pos;
        logic dx_neg;
        logic dy_pos;
        logic dy_neg;
        logic miss;
    } dir_t;

    function automatic dir_t decode_dir(input logic [3:0] code);
        dir_t d;
        d = '0;
        case (code)
            DIR_SERVE:        d.dy_pos = 1'b1;
            DIR_UL, DIR_UL2:  begin d.dx_neg = 1'b1; d.dy_neg = 1'b1; end
            DIR_UR, DIR_UR2:  begin d.dx_pos = 1'b1; d.dy_neg = 1'b1; end
            DIR_DR, DIR_DR2:  begin d.dx_pos = 1'b1; d.dy_pos = 1'b1; end
            DIR_DL, DIR_DL2:  begin d.dx_neg = 1'b1; d.dy_pos = 1'b1; end
            DIR_MISS:         d.miss = 1'b1;
            default:          d = '0;
        endcase
        return d;
    endfunction

    // Saturate a signed 11-bit coordinate into [lo, hi]
    function automatic logic [9:0] clamp_axis(input logic signed [10:0] v,
                                              input int lo, input int hi);
        int vi;
        vi = int'(v);
        if (vi < lo)
            return 10'(lo);
        else if (vi > hi)
            return 10'(hi);
        else
            return v[9:0];
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Ball-motion bus: direction code in, position/status out.
// master = ball_motion side, slave = collision controller / renderer side.
interface ball_motion_if;
    logic [3:0] state_in;
    logic [9:0] ball_pixel_x;
    logic [9:0] ball_pixel_y;
    logic       serving;
    logic [3:0] miss_count;
    logic       tick;

    modport master (
        input  state_in,
        output ball_pixel_x, ball_pixel_y, serving, miss_count, tick
    );

    modport slave (
        output state_in,
        input  ball_pixel_x, ball_pixel_y, serving, miss_count, tick
    );
endinterface

// File: rtl/ball_motion_tick_gen.sv
// Motion-tick generator: free-running 0..TICK_DIV-1 counter, strobe on the
// last count. Shared with paddle motion.
module tick_gen #(
    parameter int TICK_DIV = 416667
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Counter advances every cycle and wraps after the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/ball_motion.sv
// Ball position controller. Serves from (X_INIT, Y_INIT), holds for
// SERVE_DELAY ticks, then steps by the decoded direction once per tick,
// clamped to the playfield. A one-cycle miss code returns to serve.
// Optional macro BALL_SPEEDUP_EN: step grows on each paddle hit up to
// MAX_STEP and resets on a miss.
//
//  state    | meaning
//  ST_SERVE | ball pinned at serve point, counting down serve delay
//  ST_MOVE  | ball advances on each tick, miss returns to ST_SERVE
module ball_motion
    import pong_pkg::*;
#(
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int STEP        = 2,
    parameter int TICK_DIV    = 416667,
    parameter int SERVE_DELAY = 60,
    parameter int MAX_STEP    = 6
) (
    input  logic          clk,
    input  logic          rst,
    ball_motion_if.master bus
);
    localparam int DW = $clog2(SERVE_DELAY + 2);
    localparam logic [DW-1:0] DELAY_INIT = DW'(SERVE_DELAY);
    localparam logic [9:0]    X_SERVE    = 10'(X_INIT);
    localparam logic [9:0]    Y_SERVE    = 10'(Y_INIT);
    localparam logic [3:0]    STEP_INIT  = 4'(STEP);

    motion_state_t   state_q, state_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic [3:0]      miss_q, miss_d;
    logic [3:0]      step_cur;
    logic            tick;
    logic            miss_event;
    dir_t            dir;
    logic signed [10:0] sx, sy, stp, nx, ny;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign dir        = decode_dir(bus.state_in);
    assign miss_event = (state_q == ST_MOVE) && dir.miss;

`ifdef BALL_SPEEDUP_EN
    localparam logic [3:0] STEP_CAP = 4'(MAX_STEP);
    logic [3:0] step_q;
    logic [3:0] prev_q;
    logic       hit;

    // Paddle hit: outgoing-to-paddle code flips to a bounced-up code
    assign hit = ((prev_q == DIR_SERVE) || (prev_q == DIR_DR) || (prev_q == DIR_DL2)) &&
                 ((bus.state_in == DIR_UL) || (bus.state_in == DIR_UR));
    assign step_cur = step_q;

    // Step speeds up on hits, falls back to the serve speed on a miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= STEP_INIT;
            prev_q <= DIR_HOLD;
        end else begin
            prev_q <= bus.state_in;
            if (miss_event)
                step_q <= STEP_INIT;
            else if (hit && (step_q < STEP_CAP))
                step_q <= step_q + 4'd1;
        end
    end
`else
    assign step_cur = STEP_INIT;
`endif

    assign sx  = $signed({1'b0, x_q});
    assign sy  = $signed({1'b0, y_q});
    assign stp = $signed({7'd0, step_cur});
    assign nx  = dir.dx_pos ? (sx + stp) : (dir.dx_neg ? (sx - stp) : sx);
    assign ny  = dir.dy_pos ? (sy + stp) : (dir.dy_neg ? (sy - stp) : sy);

    // State, position, delay and miss registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SERVE;
            delay_q <= DELAY_INIT;
            x_q     <= X_SERVE;
            y_q     <= Y_SERVE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            x_q     <= x_d;
            y_q     <= y_d;
            miss_q  <= miss_d;
        end
    end

    // Next-state: serve countdown, per-tick step, miss has priority over tick
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        x_d     = x_q;
        y_d     = y_q;
        miss_d  = miss_q;
        case (state_q)
            ST_SERVE: begin
                x_d = X_SERVE;
                y_d = Y_SERVE;
                if (tick) begin
                    // a zero delay is treated as a one-tick hold
                    if (delay_q <= DW'(1))
                        state_d = ST_MOVE;
                    else
                        delay_d = delay_q - DW'(1);
                end
            end
            ST_MOVE: begin
                if (dir.miss) begin
                    state_d = ST_SERVE;
                    delay_d = DELAY_INIT;
                    x_d     = X_SERVE;
                    y_d     = Y_SERVE;
                    if (miss_q != 4'hF)
                        miss_d = miss_q + 4'd1;
                end else if (tick) begin
                    x_d = clamp_axis(nx, X_MIN, X_MAX);
                    y_d = clamp_axis(ny, Y_MIN, Y_MAX);
                end
            end
            default: state_d = ST_SERVE;
        endcase
    end

    assign bus.ball_pixel_x = x_q;
    assign bus.ball_pixel_y = y_q;
    assign bus.serving      = (state_q == ST_SERVE);
    assign bus.miss_count   = miss_q;
    assign bus.tick         = tick;

endmodule
